// File: rtl/seg7_pkg.sv
// Shared constants for the 7-segment scan controller: segment bit positions,
// the nibble-to-glyph table and the scan FSM state type.
package seg7_pkg;

  // Bit positions inside SEG = {a,b,c,d,e,f,g,dp}
  localparam int SEG_A  = 7;
  localparam int SEG_B  = 6;
  localparam int SEG_C  = 5;
  localparam int SEG_D  = 4;
  localparam int SEG_E  = 3;
  localparam int SEG_F  = 2;
  localparam int SEG_G  = 1;
  localparam int SEG_DP = 0;

  localparam logic [6:0] GLYPH_BLANK = 7'b0000000;

  // Segments a..g for nibble values 0..F
  localparam logic [6:0] GLYPH_TABLE [16] = '{
    7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
    7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
    7'b1111111, 7'b1111011, 7'b1110111, 7'b0011111,
    7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111
  };

  typedef enum logic {
    IDLE = 1'b0,
    SCAN = 1'b1
  } scan_state_e;

endpackage

// File: rtl/seg7_scan_ctrl_if.sv
// Display-side bundle of the scan controller: value/mask/enable in, COM/SEG
// pins and the frame pulse out.
interface seg7_scan_ctrl_if #(
  parameter int NUM_DIGITS = 4
) ();
  logic                      EN;
  logic [4*NUM_DIGITS-1:0]   Data_Bin;
  logic [NUM_DIGITS-1:0]     DP_Mask;
  logic [NUM_DIGITS-1:0]     COM;
  logic [7:0]                SEG;
  logic                      Frame_Done;

  modport master (
    output EN, Data_Bin, DP_Mask,
    input  COM, SEG, Frame_Done
  );

  modport slave (
    input  EN, Data_Bin, DP_Mask,
    output COM, SEG, Frame_Done
  );
endinterface

// File: rtl/seg7_decoder.sv
// Combinational nibble-to-segment (a..g) decoder; values above 9 are dark
// unless HEX_MODE selects the A-F glyphs.
module seg7_decoder
  import seg7_pkg::*;
#(
  parameter int HEX_MODE = 0
) (
  input  logic [3:0] nibble,
  output logic [6:0] glyph
);

  always_comb begin
    // NOTE: every combinational output gets a default first, so no path can
    // leave it unassigned and infer a latch.
    glyph = GLYPH_TABLE[nibble];
    if (HEX_MODE == 0 && nibble > 4'd9) glyph = GLYPH_BLANK;
  end

endmodule

// File: rtl/seg7_scan_ctrl.sv
// Time-multiplexed common-select 7-segment scanner with per-slot blank gap
// and frame-aligned snapshots. Define SEG7_LZ_BLANK_EN for leading-zero blanking.
module seg7_scan_ctrl
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS   = 4,
  parameter int DIV_COUNT    = 5000,
  parameter int BLANK_CYCLES = 16,
  parameter int HEX_MODE     = 0
) (
  input  logic             Sys_CLK,
  input  logic             Sys_RST,
  seg7_scan_ctrl_if.slave  bus
);

  localparam int CNT_W = $clog2(DIV_COUNT);
  localparam int IDX_W = $clog2(NUM_DIGITS);
  localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(DIV_COUNT - 1);
  localparam logic [CNT_W-1:0] CNT_BLANK = CNT_W'(BLANK_CYCLES);
  localparam logic [IDX_W-1:0] IDX_MAX   = IDX_W'(NUM_DIGITS - 1);

  scan_state_e state_q, state_d;
  logic [CNT_W-1:0]                cnt_q;
  logic [IDX_W-1:0]                idx_q;
  logic [NUM_DIGITS-1:0][3:0]      snap_data_q;
  logic [NUM_DIGITS-1:0]           snap_dp_q;
  logic [NUM_DIGITS-1:0]           com_q, com_d;
  logic [7:0]                      seg_q, seg_d;
  logic                            frame_done_q;
  logic [6:0]                      glyph;
  logic                            scanning, slot_end, frame_end, reload;

  assign scanning  = (state_q == SCAN) && bus.EN;
  assign slot_end  = (cnt_q == CNT_MAX);
  assign frame_end = slot_end && (idx_q == IDX_MAX);
  // Snapshots load on scan entry and at every frame wrap, never mid-frame.
  assign reload    = ((state_q == IDLE) && bus.EN) || (scanning && frame_end);

  seg7_decoder #(.HEX_MODE(HEX_MODE)) u_decoder (
    .nibble (snap_data_q[idx_q]),
    .glyph  (glyph)
  );

`ifdef SEG7_LZ_BLANK_EN
  logic [NUM_DIGITS-1:0] lz_mask_q;

  // Digit k is a leading zero when it and every digit above it are zero.
  function automatic logic [NUM_DIGITS-1:0] lz_mask(input logic [NUM_DIGITS-1:0][3:0] data);
    logic [NUM_DIGITS-1:0] mask;
    logic seen;
    mask = '0;
    seen = 1'b0;
    for (int k = NUM_DIGITS - 1; k > 0; k--) begin
      seen    = seen | (data[k] != 4'd0);
      mask[k] = !seen;
    end
    return mask;
  endfunction

  always_ff @(posedge Sys_CLK) begin
    if (Sys_RST)     lz_mask_q <= '0;
    else if (reload) lz_mask_q <= lz_mask(bus.Data_Bin);
  end
`endif

  always_ff @(posedge Sys_CLK) begin
    if (Sys_RST) state_q <= IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.EN)  state_d = SCAN;
      SCAN:    if (!bus.EN) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    com_d = '0;
    seg_d = '0;
    if (state_q == SCAN && cnt_q >= CNT_BLANK) begin
      com_d                = NUM_DIGITS'(1) << idx_q;
      seg_d[SEG_A:SEG_G]   = glyph;
      seg_d[SEG_DP]        = snap_dp_q[idx_q];
`ifdef SEG7_LZ_BLANK_EN
      if (lz_mask_q[idx_q]) seg_d[SEG_A:SEG_G] = GLYPH_BLANK;
`endif
    end
  end

  always_ff @(posedge Sys_CLK) begin
    // NOTE: non-blocking assignments so every register here samples the
    // pre-edge values of the others, independent of statement order.
    if (Sys_RST) begin
      cnt_q        <= '0;
      idx_q        <= '0;
      // NOTE: the snapshots are a handful of flops, not a RAM, so they take
      // the reset like the rest of the state.
      snap_data_q  <= '0;
      snap_dp_q    <= '0;
      com_q        <= '0;
      seg_q        <= '0;
      frame_done_q <= 1'b0;
    end else begin
      com_q        <= com_d;
      seg_q        <= seg_d;
      frame_done_q <= scanning && frame_end;
      if (reload) begin
        snap_data_q <= bus.Data_Bin;
        snap_dp_q   <= bus.DP_Mask;
      end
      if (scanning) begin
        if (!slot_end) begin
          cnt_q <= cnt_q + 1'b1;
        end else begin
          cnt_q <= '0;
          idx_q <= frame_end ? '0 : idx_q + 1'b1;
        end
      end else begin
        cnt_q <= '0;
        idx_q <= '0;
      end
    end
  end

  assign bus.COM        = com_q;
  assign bus.SEG        = seg_q;
  assign bus.Frame_Done = frame_done_q;

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Self-checking bench: a decimal and a hex instance share stimulus and are
// compared every cycle against a slot-arithmetic model of the scan.
module tb_seg7_scan_ctrl;

  localparam int N     = 4;
  localparam int DIV   = 8;
  localparam int BLANK = 2;
  localparam int FRAME = N * DIV;

  localparam logic [6:0] REF_GLYPH [16] = '{
    7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
    7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
    7'b1111111, 7'b1111011, 7'b1110111, 7'b0011111,
    7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111
  };

  logic          clk;
  logic          rst;
  logic          en;
  logic [15:0]   data;
  logic [3:0]    dp;

  int vectors     = 0;
  int miscompares = 0;

  // Model state: running flag, cycles since scan entry, frame snapshot
  bit          m_run  = 0;
  int          m_t    = 0;
  logic [15:0] m_data = '0;
  logic [3:0]  m_dp   = '0;

  seg7_scan_ctrl_if #(.NUM_DIGITS(N)) if_dec ();
  seg7_scan_ctrl_if #(.NUM_DIGITS(N)) if_hex ();

  assign if_dec.EN = en;  assign if_dec.Data_Bin = data;  assign if_dec.DP_Mask = dp;
  assign if_hex.EN = en;  assign if_hex.Data_Bin = data;  assign if_hex.DP_Mask = dp;

  seg7_scan_ctrl #(.NUM_DIGITS(N), .DIV_COUNT(DIV), .BLANK_CYCLES(BLANK), .HEX_MODE(0)) dut_dec (
    .Sys_CLK (clk), .Sys_RST (rst), .bus (if_dec.slave)
  );
  seg7_scan_ctrl #(.NUM_DIGITS(N), .DIV_COUNT(DIV), .BLANK_CYCLES(BLANK), .HEX_MODE(1)) dut_hex (
    .Sys_CLK (clk), .Sys_RST (rst), .bus (if_hex.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %b expected %b (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [7:0] ref_seg(input int hex, input logic [15:0] d16,
                                         input logic [3:0] m, input int d);
    logic [3:0] nib;
    logic [6:0] g;
    nib = 4'((d16 >> (4 * d)) & 16'hF);
    g   = (nib > 4'd9 && hex == 0) ? 7'b0 : REF_GLYPH[nib];
`ifdef SEG7_LZ_BLANK_EN
    if (d > 0 && (d16 >> (4 * d)) == 16'h0) g = 7'b0;
`endif
    return {g, m[d]};
  endfunction

  // One clock: predict outputs from the pre-edge model, advance, then compare.
  task automatic tick();
    logic [7:0] e_com, e_dec, e_hex;
    logic       e_fd;
    int         dig;
    e_com = '0; e_dec = '0; e_hex = '0; e_fd = 1'b0;
    if (!rst && m_run && (m_t % DIV) >= BLANK) begin
      dig   = (m_t / DIV) % N;
      e_com = 8'(1 << dig);
      e_dec = ref_seg(0, m_data, m_dp, dig);
      e_hex = ref_seg(1, m_data, m_dp, dig);
    end
    if (!rst) e_fd = m_run && en && ((m_t % FRAME) == FRAME - 1);

    if (rst) m_run = 0;
    else if (!m_run && en) begin
      m_run = 1; m_t = 0; m_data = data; m_dp = dp;
    end else if (m_run && en) begin
      m_t++;
      if (m_t % FRAME == 0) begin m_data = data; m_dp = dp; end
    end else if (m_run) m_run = 0;

    @(posedge clk);
    #1;
    check("com_dec", 8'(if_dec.COM), e_com);
    check("seg_dec", if_dec.SEG, e_dec);
    check("fd_dec", 8'(if_dec.Frame_Done), 8'(e_fd));
    check("com_hex", 8'(if_hex.COM), e_com);
    check("seg_hex", if_hex.SEG, e_hex);
    check("fd_hex", 8'(if_hex.Frame_Done), 8'(e_fd));
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // Wait (bounded) for a digit to light, then compare both instances to constants.
  task automatic spot(input string tag, input logic [3:0] com,
                      input logic [7:0] exp_dec, input logic [7:0] exp_hex);
    bit found;
    found = 0;
    for (int i = 0; i < 2 * FRAME && !found; i++) begin
      tick();
      found = (if_dec.COM == com);
    end
    check({tag, "_timeout"}, 8'(found), 8'd1);
    check({tag, "_dec"}, if_dec.SEG, exp_dec);
    check({tag, "_hex"}, if_hex.SEG, exp_hex);
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; data = 16'h0; dp = 4'h0;
    run(3);

    // Basic scan of 0x1234
    rst = 1'b0; en = 1'b1; data = 16'h1234;
    run(2 * FRAME + 3);
    spot("d0_1234", 4'b0001, 8'b01100110, 8'b01100110);

    // Mid-frame change must wait for the frame boundary
    run(DIV + 3);
    data = 16'h5678;
    run(2 * FRAME);

    // Hex glyphs and decimal point
    data = 16'h00AF; dp = 4'b0010;
    run(FRAME + 5);
    spot("d0_af", 4'b0001, 8'b00000000, 8'b10001110);
    spot("d1_af", 4'b0010, 8'b00000001, 8'b11101111);

    // EN drop mid-slot, then restart
    run(DIV / 2);
    en = 1'b0;
    run(4);
    en = 1'b1;
    run(FRAME + 4);

    // Reset mid-slot
    rst = 1'b1;
    run(1);
    rst = 1'b0;
    run(FRAME + 6);

    // Leading-zero patterns
    data = 16'h0040; dp = 4'b1000;
    run(2 * FRAME);
    data = 16'h0000; dp = 4'b0000;
    run(2 * FRAME);

    // Randomised segments of stimulus
    for (int k = 0; k < 40; k++) begin
      data = 16'($urandom_range(0, 65535) >> (4 * $urandom_range(0, 3)));
      dp   = 4'($urandom_range(0, 15));
      en   = ($urandom_range(0, 5) != 0);
      rst  = ($urandom_range(0, 9) == 0);
      tick();
      rst  = 1'b0;
      run($urandom_range(1, 40));
    end
    en = 1'b1;
    run(2 * FRAME);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
